// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared constants and types for the RAM arbiter slice.
//   - word/reset/write-enable encodings reused across the memory path
//   - default starvation limit and RAM depth
//   - grant encoding (NONE/INST/DATA) and the per-port response struct
package ram_arbiter_pkg;

    localparam int          XLEN           = 32;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic        RST_ENABLE     = 1'b1;
    localparam logic        WRITE_ENABLE   = 1'b1;

    localparam int          ARB_STARVE_MAX = 4;
    localparam int          ARB_RAM_DEPTH  = 4096;

    // Port slots in the per-port packed arrays
    localparam int          NUM_PORTS      = 2;
    localparam int          PORT_I         = 0;
    localparam int          PORT_D         = 1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_INST = 2'b01,
        GNT_DATA = 2'b10
    } grant_e;

    typedef struct packed {
        logic            ack;
        logic            err;
        logic [XLEN-1:0] rdata;
    } port_rsp_t;

    // Saturating increment of the 4-bit starvation counter
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt, input logic [3:0] lim);
        return (cnt >= lim) ? lim : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the fetch port, load/store port, RAM-side bus and
// pipeline stall line of the RAM arbiter.
//   slave  : arbiter view (requests in, responses/RAM controls out)
//   master : requester/environment view (mirror image)
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    // Fetch port
    logic            i_req_i;
    logic [XLEN-1:0] i_addr_i;
    logic            i_ack_o;
    logic            i_err_o;
    logic [XLEN-1:0] i_rdata_o;
    // Load/store port
    logic            d_req_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_addr_i;
    logic [XLEN-1:0] d_wdata_i;
    logic            d_ack_o;
    logic            d_err_o;
    logic [XLEN-1:0] d_rdata_o;
    // RAM side
    logic            ram_we_o;
    logic [XLEN-1:0] ram_addr_o;
    logic [XLEN-1:0] ram_wdata_o;
    logic [XLEN-1:0] ram_rdata_i;
    // Pipeline control / debug
    logic            stall_req_o;
    grant_e          last_grant_o;

    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, ram_rdata_i,
        output i_ack_o, i_err_o, i_rdata_o, d_ack_o, d_err_o, d_rdata_o,
               ram_we_o, ram_addr_o, ram_wdata_o, stall_req_o, last_grant_o
    );

    modport master (
        output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, ram_rdata_i,
        input  i_ack_o, i_err_o, i_rdata_o, d_ack_o, d_err_o, d_rdata_o,
               ram_we_o, ram_addr_o, ram_wdata_o, stall_req_o, last_grant_o
    );

endinterface

// File: rtl/ram_arbiter_mem_addr_check.sv
// ram_arbiter_mem_addr_check: combinational access-fault detector for one port.
//   addr_i  : byte address of the request
//   fault_o : 1 when the address is not word aligned or its word index
//             is at or beyond RAM_DEPTH
module ram_arbiter_mem_addr_check
    import ram_arbiter_pkg::*;
#(
    parameter int RAM_DEPTH = ARB_RAM_DEPTH
) (
    input  logic [XLEN-1:0] addr_i,
    output logic            fault_o
);

    logic misaligned;
    logic out_of_range;

    assign misaligned   = (addr_i[1:0] != 2'b00);
    // Compare the full 30-bit word index so huge addresses never alias into range
    assign out_of_range = ({2'b00, addr_i[XLEN-1:2]} >= 32'(RAM_DEPTH));
    assign fault_o      = misaligned | out_of_range;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM between the fetch port (I, read only)
// and the load/store port (D). One access per cycle, D has priority, but a
// fetch denied STARVE_MAX cycles in a row wins the next arbitration.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ram_arbiter_if.slave (requests, responses, RAM bus, stall)
// Responses are registered: a grant in cycle N acks in cycle N+1.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX,
    parameter int RAM_DEPTH  = ARB_RAM_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [NUM_PORTS-1:0][XLEN-1:0] port_addr;
    logic [NUM_PORTS-1:0]           fault;

    logic      rst_on;
    logic      starve_hit;
    logic      gnt_i;
    logic      gnt_d;
    logic      ram_we;

    port_rsp_t i_rsp_d, i_rsp_q;
    port_rsp_t d_rsp_d, d_rsp_q;
    logic [3:0] starve_d, starve_q;
    grant_e     last_grant_d, last_grant_q;

    assign port_addr[PORT_I] = bus.i_addr_i;
    assign port_addr[PORT_D] = bus.d_addr_i;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_chk
        ram_arbiter_mem_addr_check #(
            .RAM_DEPTH (RAM_DEPTH)
        ) u_chk (
            .addr_i  (port_addr[g]),
            .fault_o (fault[g])
        );
    end

    always_comb begin
        rst_on       = (rst == RST_ENABLE);
        // Fetch has waited long enough: it takes this slot even if D asks
        starve_hit   = bus.i_req_i && (starve_q == STARVE_LIM);
        gnt_d        = bus.d_req_i && !starve_hit;
        gnt_i        = bus.i_req_i && !gnt_d;

        ram_we            = 1'b0;
        bus.ram_addr_o    = ZERO_WORD;
        bus.ram_wdata_o   = ZERO_WORD;
        last_grant_d      = GNT_NONE;

        if (gnt_d) begin
            bus.ram_addr_o  = bus.d_addr_i;
            bus.ram_wdata_o = bus.d_wdata_i;
            // A faulted store still burns the slot but must not touch the RAM
            ram_we          = (bus.d_we_i == WRITE_ENABLE) && !fault[PORT_D];
            last_grant_d    = GNT_DATA;
        end else if (gnt_i) begin
            bus.ram_addr_o  = bus.i_addr_i;
            last_grant_d    = GNT_INST;
        end

        // Reset wins over any in-flight store
        bus.ram_we_o    = ram_we && !rst_on;
        bus.stall_req_o = !rst_on && ((bus.i_req_i && !gnt_i) || (bus.d_req_i && !gnt_d));

        i_rsp_d.ack   = gnt_i;
        i_rsp_d.err   = gnt_i && fault[PORT_I];
        i_rsp_d.rdata = (gnt_i && !fault[PORT_I]) ? bus.ram_rdata_i : ZERO_WORD;

        d_rsp_d.ack   = gnt_d;
        d_rsp_d.err   = gnt_d && fault[PORT_D];
        // Stores return ZeroWord, only clean loads capture RAM data
        d_rsp_d.rdata = (gnt_d && !fault[PORT_D] && !bus.d_we_i) ? bus.ram_rdata_i : ZERO_WORD;

        starve_d = (bus.i_req_i && !gnt_i) ? starve_inc(starve_q, STARVE_LIM) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            i_rsp_q      <= '0;
            d_rsp_q      <= '0;
            starve_q     <= 4'd0;
            last_grant_q <= GNT_NONE;
        end else begin
            i_rsp_q      <= i_rsp_d;
            d_rsp_q      <= d_rsp_d;
            starve_q     <= starve_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.i_ack_o      = i_rsp_q.ack;
    assign bus.i_err_o      = i_rsp_q.err;
    assign bus.i_rdata_o    = i_rsp_q.rdata;
    assign bus.d_ack_o      = d_rsp_q.ack;
    assign bus.d_err_o      = d_rsp_q.err;
    assign bus.d_rdata_o    = d_rsp_q.rdata;
    assign bus.last_grant_o = last_grant_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a RAM model and a
// transaction-level reference (shadow memory + wait counter for fetch).
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int STARVE_MAX = 4;
    localparam int RAM_DEPTH  = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if bus ();

    ram_arbiter #(.STARVE_MAX(STARVE_MAX), .RAM_DEPTH(RAM_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: combinational read, write at clock edge; preload port for setup
    logic [31:0] ram [RAM_DEPTH];
    logic        pre_we = 1'b0;
    logic [11:0] pre_idx = '0;
    logic [31:0] pre_data = '0;
    int          we_cnt = 0;

    assign bus.ram_rdata_i = ram[bus.ram_addr_o[13:2]];
    always @(posedge clk) begin
        if (pre_we) ram[pre_idx] <= pre_data;
        else if (bus.ram_we_o) ram[bus.ram_addr_o[13:2]] <= bus.ram_wdata_o;
        if (bus.ram_we_o) we_cnt <= we_cnt + 1;
    end

    // Requesters must hold req until ack
    logic prev_i = 1'b0, prev_d = 1'b0, prev_ok = 1'b0;
    always @(posedge clk) begin
        if (prev_ok && !rst) begin
            if (prev_i && !bus.i_ack_o) assert (bus.i_req_i) else $error("fetch req dropped before ack");
            if (prev_d && !bus.d_ack_o) assert (bus.d_req_i) else $error("data req dropped before ack");
        end
        prev_i  <= bus.i_req_i;
        prev_d  <= bus.d_req_i;
        prev_ok <= !rst;
    end

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ref_mem [RAM_DEPTH];
    int          m_wait = 0;
    logic        e_we, e_stall;
    logic        n_iack, n_ierr, n_dack, n_derr;
    logic [31:0] n_irdata, n_drdata;
    logic        e_iack = 0, e_ierr = 0, e_dack = 0, e_derr = 0;
    logic [31:0] e_irdata = 0, e_drdata = 0;

    function automatic logic is_fault(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= 32'(RAM_DEPTH));
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        logic [31:0] w = 32'($urandom_range(0, 31)) << 2;
        if (r == 0) return w | 32'($urandom_range(1, 3));
        if (r == 1) return 32'h0000_4000 + w;
        return w;
    endfunction

    // Predict this cycle's grant from the current inputs and the results
    // that will be visible after the next clock edge.
    task automatic predict();
        logic gi, gd;
        gi = 0; gd = 0; e_we = 0; e_stall = 0;
        n_iack = 0; n_ierr = 0; n_irdata = 0; n_dack = 0; n_derr = 0; n_drdata = 0;
        if (rst) begin
            m_wait = 0;
            return;
        end
        if (bus.d_req_i && !(bus.i_req_i && m_wait >= STARVE_MAX)) gd = 1;
        else if (bus.i_req_i) gi = 1;
        e_stall = (bus.i_req_i && !gi) || (bus.d_req_i && !gd);
        m_wait  = (bus.i_req_i && !gi) ? m_wait + 1 : 0;
        if (gi) begin
            n_iack = 1;
            n_ierr = is_fault(bus.i_addr_i);
            if (!n_ierr) n_irdata = ref_mem[bus.i_addr_i[13:2]];
        end
        if (gd) begin
            n_dack = 1;
            n_derr = is_fault(bus.d_addr_i);
            if (!n_derr && bus.d_we_i) begin
                e_we = 1;
                ref_mem[bus.d_addr_i[13:2]] = bus.d_wdata_i;
            end else if (!n_derr) begin
                n_drdata = ref_mem[bus.d_addr_i[13:2]];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        e_iack = n_iack; e_ierr = n_ierr; e_irdata = n_irdata;
        e_dack = n_dack; e_derr = n_derr; e_drdata = n_drdata;
        @(negedge clk);
    endtask

    task automatic set_i(input logic req, input logic [31:0] a);
        bus.i_req_i = req; bus.i_addr_i = a;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
        bus.d_req_i = req; bus.d_we_i = we; bus.d_addr_i = a; bus.d_wdata_i = wd;
    endtask

    task automatic test_reset();
        rst = 1;
        set_i(1, 32'h10); set_d(1, 1, 32'h40, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            predict(); #1;
            checks++; if (bus.ram_we_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b want=0", bus.ram_we_o); end
            checks++; if (bus.stall_req_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b want=0", bus.stall_req_o); end
            tick();
            checks++;
            if ({bus.i_ack_o, bus.i_err_o, bus.d_ack_o, bus.d_err_o} !== 4'b0 || bus.i_rdata_o !== 32'h0 || bus.d_rdata_o !== 32'h0) begin
                failures++; $display("FAIL rst_outputs got=%b/%h/%h want=0000/0/0",
                    {bus.i_ack_o, bus.i_err_o, bus.d_ack_o, bus.d_err_o}, bus.i_rdata_o, bus.d_rdata_o);
            end
        end
        set_i(0, 0); set_d(0, 0, 0, 0);
        // Preload RAM words 0..31 and the last word while still in reset
        for (int w = 0; w < 33; w++) begin
            pre_idx  = (w == 32) ? 12'd4095 : 12'(w);
            pre_data = (w == 4) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[pre_idx] = pre_data;
            pre_we = 1;
            @(negedge clk);
        end
        pre_we = 0;
        rst = 0;
        predict(); #1; tick();
        checks++; if (bus.last_grant_o !== GNT_NONE) begin failures++; $display("FAIL idle_last_grant got=%0d want=0", bus.last_grant_o); end
    endtask

    task automatic test_lone_fetch();
        set_i(1, 32'h10);
        predict(); #1;
        checks++; if (bus.stall_req_o !== 1'b0) begin failures++; $display("FAIL fetch_stall got=%0b want=0", bus.stall_req_o); end
        checks++; if (bus.ram_addr_o !== 32'h10) begin failures++; $display("FAIL fetch_addr got=%h want=00000010", bus.ram_addr_o); end
        tick();
        checks++; if (bus.i_ack_o !== 1'b1 || bus.i_err_o !== 1'b0) begin failures++; $display("FAIL fetch_ack got=%0b%0b want=10", bus.i_ack_o, bus.i_err_o); end
        checks++; if (bus.i_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_rdata got=%h want=deadbeef", bus.i_rdata_o); end
        set_i(0, 0);
        predict(); #1; tick();
        checks++; if (bus.i_ack_o !== 1'b0) begin failures++; $display("FAIL fetch_pulse got=%0b want=0", bus.i_ack_o); end
    endtask

    task automatic test_store_load();
        int w0 = we_cnt;
        set_d(1, 1, 32'h40, 32'h1234_5678);
        predict(); #1;
        checks++; if (bus.ram_we_o !== 1'b1 || bus.ram_addr_o !== 32'h40 || bus.ram_wdata_o !== 32'h1234_5678) begin
            failures++; $display("FAIL store_bus got=%0b/%h/%h want=1/00000040/12345678", bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o); end
        tick();
        checks++; if (bus.d_ack_o !== 1'b1 || bus.d_rdata_o !== 32'h0) begin failures++; $display("FAIL store_ack got=%0b/%h want=1/0", bus.d_ack_o, bus.d_rdata_o); end
        set_d(1, 0, 32'h40, 32'h0);
        predict(); #1; tick();
        checks++; if (bus.d_ack_o !== 1'b1 || bus.d_rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL load_after_store got=%0b/%h want=1/12345678", bus.d_ack_o, bus.d_rdata_o); end
        set_d(0, 0, 0, 0);
        predict(); #1; tick();
        checks++; if (we_cnt - w0 !== 1) begin failures++; $display("FAIL store_we_cycles got=%0d want=1", we_cnt - w0); end
    endtask

    task automatic test_starvation();
        set_i(1, 32'h10); set_d(1, 0, 32'h40, 0);
        for (int k = 0; k < 15; k++) begin
            predict(); #1;
            checks++; if (bus.stall_req_o !== 1'b1) begin failures++; $display("FAIL starve_stall cyc=%0d got=%0b want=1", k, bus.stall_req_o); end
            tick();
            checks++; if (bus.i_ack_o !== (k % 5 == 4) || bus.d_ack_o !== (k % 5 != 4)) begin
                failures++; $display("FAIL starve_pattern cyc=%0d got=i%0b d%0b want=i%0b d%0b", k, bus.i_ack_o, bus.d_ack_o, k % 5 == 4, k % 5 != 4); end
            checks++; if (bus.i_rdata_o !== e_irdata || bus.d_rdata_o !== e_drdata) begin
                failures++; $display("FAIL starve_data cyc=%0d got=%h/%h want=%h/%h", k, bus.i_rdata_o, bus.d_rdata_o, e_irdata, e_drdata); end
        end
        checks++; if (bus.last_grant_o !== GNT_INST) begin failures++; $display("FAIL starve_last_grant got=%0d want=1", bus.last_grant_o); end
        set_i(0, 0);
        predict(); #1; tick();
        checks++; if (bus.d_ack_o !== 1'b1) begin failures++; $display("FAIL starve_drain got=%0b want=1", bus.d_ack_o); end
        set_d(0, 0, 0, 0);
        predict(); #1; tick();
    endtask

    task automatic test_faults();
        set_d(1, 1, 32'h42, 32'hAAAA_5555);
        predict(); #1;
        checks++; if (bus.ram_we_o !== 1'b0) begin failures++; $display("FAIL misalign_we got=%0b want=0", bus.ram_we_o); end
        tick();
        checks++; if ({bus.d_ack_o, bus.d_err_o} !== 2'b11 || bus.d_rdata_o !== 32'h0) begin
            failures++; $display("FAIL misalign_rsp got=%b/%h want=11/0", {bus.d_ack_o, bus.d_err_o}, bus.d_rdata_o); end
        set_d(1, 0, 32'h40, 0);
        predict(); #1; tick();
        checks++; if (bus.d_rdata_o !== 32'h1234_5678 || bus.d_err_o !== 1'b0) begin
            failures++; $display("FAIL misalign_nowrite got=%h want=12345678", bus.d_rdata_o); end
        set_d(0, 0, 0, 0); set_i(1, 32'h4000);
        predict(); #1; tick();
        checks++; if ({bus.i_ack_o, bus.i_err_o} !== 2'b11 || bus.i_rdata_o !== 32'h0) begin
            failures++; $display("FAIL range_fetch got=%b/%h want=11/0", {bus.i_ack_o, bus.i_err_o}, bus.i_rdata_o); end
        set_i(1, 32'h3FFC);
        predict(); #1; tick();
        checks++; if ({bus.i_ack_o, bus.i_err_o} !== 2'b10 || bus.i_rdata_o !== ref_mem[4095]) begin
            failures++; $display("FAIL last_word_fetch got=%b/%h want=10/%h", {bus.i_ack_o, bus.i_err_o}, bus.i_rdata_o, ref_mem[4095]); end
        set_i(0, 0);
        predict(); #1; tick();
    endtask

    task automatic test_reset_midstore();
        logic [31:0] old31 = ref_mem[31];
        set_i(1, 32'h10); set_d(1, 0, 32'h40, 0);
        predict(); #1; tick();
        predict(); #1; tick();
        // D just acked; a new store request meets reset in its grant cycle
        set_d(1, 1, 32'h7C, 32'hCAFE_F00D);
        rst = 1;
        predict(); #1;
        checks++; if (bus.ram_we_o !== 1'b0) begin failures++; $display("FAIL rst_store_we got=%0b want=0", bus.ram_we_o); end
        tick();
        rst = 0; set_i(0, 0); set_d(0, 0, 0, 0);
        checks++; if (bus.d_ack_o !== 1'b0 || bus.i_ack_o !== 1'b0) begin failures++; $display("FAIL rst_store_ack got=%0b%0b want=00", bus.i_ack_o, bus.d_ack_o); end
        predict(); #1; tick();
        checks++; if ({bus.i_ack_o, bus.d_ack_o, bus.i_err_o, bus.d_err_o} !== 4'b0 || bus.i_rdata_o !== 0 || bus.d_rdata_o !== 0) begin
            failures++; $display("FAIL post_rst_outputs got=%b want=0000", {bus.i_ack_o, bus.d_ack_o, bus.i_err_o, bus.d_err_o}); end
        checks++; if (ram[31] !== old31) begin failures++; $display("FAIL rst_store_ram got=%h want=%h", ram[31], old31); end
        // Counter restarted from zero: four D grants before I again
        set_i(1, 32'h10); set_d(1, 0, 32'h40, 0);
        for (int k = 0; k < 5; k++) begin
            predict(); #1; tick();
            checks++; if (bus.i_ack_o !== (k == 4) || bus.d_ack_o !== (k != 4)) begin
                failures++; $display("FAIL post_rst_pattern cyc=%0d got=i%0b d%0b want=i%0b d%0b", k, bus.i_ack_o, bus.d_ack_o, k == 4, k != 4); end
        end
        set_i(0, 0);
        predict(); #1; tick();
        set_d(0, 0, 0, 0);
        predict(); #1; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            predict(); #1;
            checks++; if (bus.stall_req_o !== e_stall || bus.ram_we_o !== e_we) begin
                failures++; $display("FAIL rand_comb cyc=%0d got=%0b%0b want=%0b%0b", c, bus.stall_req_o, bus.ram_we_o, e_stall, e_we); end
            tick();
            checks++; if ({bus.i_ack_o, bus.i_err_o} !== {e_iack, e_ierr} || bus.i_rdata_o !== e_irdata) begin
                failures++; $display("FAIL rand_i cyc=%0d got=%b/%h want=%b/%h", c, {bus.i_ack_o, bus.i_err_o}, bus.i_rdata_o, {e_iack, e_ierr}, e_irdata); end
            checks++; if ({bus.d_ack_o, bus.d_err_o} !== {e_dack, e_derr} || bus.d_rdata_o !== e_drdata) begin
                failures++; $display("FAIL rand_d cyc=%0d got=%b/%h want=%b/%h", c, {bus.d_ack_o, bus.d_err_o}, bus.d_rdata_o, {e_dack, e_derr}, e_drdata); end
            checks++; if (bus.i_ack_o === 1'b1 && bus.d_ack_o === 1'b1) begin
                failures++; $display("FAIL rand_dual_ack cyc=%0d got=11 want=one", c); end
            if (!bus.i_req_i || bus.i_ack_o) set_i($urandom_range(0, 3) != 0, rand_addr());
            if (!bus.d_req_i || bus.d_ack_o) set_d($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
    endtask

    initial begin
        set_i(0, 0); set_d(0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_starvation();
        test_faults();
        test_reset_midstore();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
